// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock,
// unsigned or two's-complement, with divide-by-zero and signed-overflow flags.
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_en,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         dz,
    output logic         ovf
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [N-1:0] a, b, dividend_mag, divisor_mag;
    logic [N:0] r, r_sh, t;
    logic q_neg, r_neg, ovf_p;
    assign dividend_mag = (signed_en && dividend[N-1]) ? -dividend : dividend;
    assign divisor_mag = (signed_en && divisor[N-1]) ? -divisor : divisor;
    // a shifts dividend bits out of the top while quotient bits enter at the bottom
    assign r_sh = {r[N-1:0], a[N-1]};
    assign t = r_sh - {1'b0, b};
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a         <= '0;
            b         <= '0;
            r         <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            ovf_p     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ovf <= 1'b0;
                    if (divisor == '0) begin
                        state     <= DONE;
                        quotient  <= '1;
                        remainder <= dividend;
                        dz        <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        state     <= CALC;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        a         <= dividend_mag;
                        b         <= divisor_mag;
                        r         <= '0;
                        q_neg     <= signed_en && (dividend[N-1] ^ divisor[N-1]);
                        r_neg     <= signed_en && dividend[N-1];
                        ovf_p     <= signed_en && dividend == {1'b1, {(N-1){1'b0}}} && divisor == '1;
                        quotient  <= '0;
                        remainder <= '0;
                        dz        <= 1'b0;
                    end
                end
                CALC: begin
                    a   <= {a[N-2:0], ~t[N]};
                    r   <= t[N] ? r_sh : t;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) state <= FIX;
                end
                FIX: begin
                    quotient  <= q_neg ? -a : a;
                    remainder <= r_neg ? -r[N-1:0] : r[N-1:0];
                    ovf       <= ovf_p;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table vectors, random vectors against an arithmetic model,
// and hand sequences for reset mid-operation and ignored starts.
module tb_seq_divider;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, signed_en = 1'b0;
    logic [7:0] dividend = '0, divisor = '0, quotient, remainder;
    logic busy, done, dz, ovf;
    int n_cmp = 0, n_fail = 0;

    seq_divider #(.N(8)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_en(signed_en),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .busy(busy), .done(done), .dz(dz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dd, dv;
        logic se;
        logic [7:0] q, r;
        logic dz, ovf;
        int lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // behavioural reference using plain integer division
    task automatic model(input logic [7:0] dd, input logic [7:0] dv, input logic se,
                         output logic [7:0] q, output logic [7:0] r, output logic mdz, output logic movf);
        int sd, sv, iq, ir;
        mdz = 1'b0; movf = 1'b0;
        if (dv == 0) begin
            q = 8'hFF; r = dd; mdz = 1'b1;
        end else if (!se) begin
            q = 8'(int'(dd) / int'(dv)); r = 8'(int'(dd) % int'(dv));
        end else begin
            sd = int'($signed(dd)); sv = int'($signed(dv));
            if (sd == -128 && sv == -1) begin
                q = 8'h80; r = 8'h00; movf = 1'b1;
            end else begin
                iq = sd / sv; ir = sd % sv;
                q = 8'(iq); r = 8'(ir);
            end
        end
    endtask

    task automatic do_div(input logic [7:0] dd, input logic [7:0] dv, input logic se,
                          output int lat, output int bcnt);
        dividend = dd; divisor = dv; signed_en = se; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'hA5; divisor = 8'h3C; signed_en = ~se;
        lat = -1; bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    vec_t tbl[10];

    initial begin
        logic [7:0] eq, er, dd, dv;
        logic edz, eovf, se;
        int lat, bcnt, dcnt;
        tbl = '{
            '{8'd200, 8'd7,   1'b0, 8'h1C, 8'h04, 1'b0, 1'b0, 10},
            '{8'h9C,  8'd7,   1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0, 10},
            '{8'd100, 8'hF9,  1'b1, 8'hF2, 8'h02, 1'b0, 1'b0, 10},
            '{8'd13,  8'd0,   1'b0, 8'hFF, 8'h0D, 1'b1, 1'b0, 1},
            '{8'h80,  8'hFF,  1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 10},
            '{8'h80,  8'hFF,  1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 10},
            '{8'hFF,  8'h01,  1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 10},
            '{8'hFF,  8'h01,  1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 10},
            '{8'h07,  8'h00,  1'b1, 8'hFF, 8'h07, 1'b1, 1'b0, 1},
            '{8'h81,  8'h02,  1'b1, 8'hC1, 8'hFF, 1'b0, 1'b0, 10}
        };
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", quotient, 0); chk("reset_r", remainder, 0);
        chk("reset_busy", busy, 0); chk("reset_done", done, 0);
        chk("reset_dz", dz, 0); chk("reset_ovf", ovf, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            do_div(tbl[i].dd, tbl[i].dv, tbl[i].se, lat, bcnt);
            chk($sformatf("tbl%0d_q", i), quotient, tbl[i].q);
            chk($sformatf("tbl%0d_r", i), remainder, tbl[i].r);
            chk($sformatf("tbl%0d_dz", i), dz, tbl[i].dz);
            chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_busy", i), bcnt, tbl[i].lat == 1 ? 0 : 9);
        end

        for (int i = 0; i < 200; i++) begin
            dd = 8'($urandom);
            dv = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            se = 1'($urandom);
            if (i % 50 == 0) begin dd = 8'h80; dv = 8'hFF; end
            model(dd, dv, se, eq, er, edz, eovf);
            do_div(dd, dv, se, lat, bcnt);
            chk($sformatf("rnd%0d_q(%0h/%0h s%0d)", i, dd, dv, se), quotient, eq);
            chk($sformatf("rnd%0d_r", i), remainder, er);
            chk($sformatf("rnd%0d_flags", i), {dz, ovf}, {edz, eovf});
            chk($sformatf("rnd%0d_lat", i), lat, edz ? 1 : 10);
        end

        dividend = 8'hFF; divisor = 8'hFF; signed_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_q", quotient, 0); chk("rst_mid_r", remainder, 0);
        chk("rst_mid_busy", busy, 0); chk("rst_mid_done", done, 0);
        chk("rst_mid_flags", {dz, ovf}, 0);
        dcnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        chk("rst_mid_quiet", dcnt, 0);
        do_div(8'hFF, 8'hFF, 1'b0, lat, bcnt);
        chk("after_rst_q", quotient, 1); chk("after_rst_r", remainder, 0);
        chk("after_rst_lat", lat, 10);

        dividend = 8'd50; divisor = 8'd5; signed_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        dividend = 8'd9; divisor = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0; lat = -1;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                dcnt++;
                if (lat < 0) begin
                    lat = k;
                    start = 1'b1;
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (lat >= 0 && busy) dcnt += 100;
        end
        chk("busy_start_done_cnt", dcnt, 1);
        chk("busy_start_q", quotient, 10);
        chk("busy_start_r", remainder, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
